// File: rtl/quant_matrix_loader.sv
// quant_matrix_loader: sequences MPEG-2 quantiser matrix default-restore and 64-byte zigzag loads (req_* pulses in, in_dta/in_valid/in_ready byte stream, wr_addr/wr_dta/wr_en_*/wr_clk_en/rst_values matrix write port, hold/done/timeout status; watchdog of MAX_IDLE cycles built when QM_WATCHDOG_EN is defined)
module quant_matrix_loader #(
  parameter int unsigned MAX_IDLE = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_rst_values,
  input  logic       req_intra,
  input  logic       req_non_intra,
  input  logic [7:0] in_dta,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [5:0] wr_addr,
  output logic [7:0] wr_dta,
  output logic       wr_en_intra,
  output logic       wr_en_non_intra,
  output logic       wr_clk_en,
  output logic       rst_values,
  output logic       hold,
  output logic       done,
  output logic       timeout
);
  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    RESET  = 5'b00010,
    LOAD_I = 5'b00100,
    LOAD_N = 5'b01000,
    FINISH = 5'b10000
  } state_t;
  state_t state, nxt, pick;
  logic p_rst, p_intra, p_non, pr_n, pi_n, pn_n;
  logic load, acc, last, tmo, r_left, i_left, n_left;
  logic [5:0] cnt;
`ifdef QM_WATCHDOG_EN
  logic [9:0] idle;
  assign tmo = load && !acc && idle == 10'(MAX_IDLE - 1);
  always_ff @(posedge clk) idle <= (rst || !load || acc) ? '0 : idle + 10'd1;
`else
  logic unused_max;
  assign unused_max = MAX_IDLE[0];
  assign tmo = 1'b0;
`endif
  always_comb begin
    load   = state == LOAD_I || state == LOAD_N;
    acc    = load && in_valid && in_ready;
    last   = acc && cnt == 6'd63;
    r_left = p_rst && state != RESET;
    i_left = p_intra && !(last && state == LOAD_I);
    n_left = p_non && !(last && state == LOAD_N);
    pick   = r_left ? RESET : i_left ? LOAD_I : n_left ? LOAD_N : FINISH;
    nxt    = tmo ? FINISH :
             state == IDLE ? (pick == FINISH ? IDLE : pick) :
             state == RESET ? pick :
             load ? (last ? pick : state) : IDLE;
    pr_n   = r_left || (req_rst_values && !p_rst);
    pi_n   = (i_left && !tmo) || (req_intra && !p_intra);
    pn_n   = (n_left && !tmo) || (req_non_intra && !p_non);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      p_rst           <= 1'b0;
      p_intra         <= 1'b0;
      p_non           <= 1'b0;
      cnt             <= '0;
      in_ready        <= 1'b0;
      wr_addr         <= '0;
      wr_dta          <= '0;
      wr_en_intra     <= 1'b0;
      wr_en_non_intra <= 1'b0;
      wr_clk_en       <= 1'b0;
      rst_values      <= 1'b0;
      hold            <= 1'b0;
      done            <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      state           <= nxt;
      p_rst           <= pr_n;
      p_intra         <= pi_n;
      p_non           <= pn_n;
      cnt             <= load ? cnt + 6'(acc) : '0;
      in_ready        <= nxt == LOAD_I || nxt == LOAD_N;
      wr_addr         <= acc ? cnt : wr_addr;
      wr_dta          <= acc ? in_dta : wr_dta;
      wr_en_intra     <= acc && state == LOAD_I;
      wr_en_non_intra <= acc && state == LOAD_N;
      wr_clk_en       <= acc || state == RESET;
      rst_values      <= state == RESET;
      hold            <= nxt != IDLE || pr_n || pi_n || pn_n;
      done            <= state == FINISH;
      timeout         <= tmo;
    end
  end
endmodule

// File: tb/tb_quant_matrix_loader.sv
// tb_quant_matrix_loader: directed self-checking bench for quant_matrix_loader
`timescale 1ns/1ps
module tb_quant_matrix_loader;
  logic clk = 1'b0, rst = 1'b1, req_rst_values = 1'b0, req_intra = 1'b0, req_non_intra = 1'b0, in_valid = 1'b0;
  logic [7:0] in_dta = 8'h00;
  logic in_ready, wr_en_intra, wr_en_non_intra, wr_clk_en, rst_values, hold, done, timeout;
  logic [5:0] wr_addr;
  logic [7:0] wr_dta;
  int total = 0, bad = 0, cyc = 0, req_edge = 0;
  int ni, nn, nrv, nd, nt, nt_all, ce_bad, wi_cyc, wn_cyc, rv_cyc, done_cyc, t_cyc;
  logic [5:0] ia [256];
  logic [5:0] na [256];
  logic [7:0] idt [256];
  logic [7:0] ndt [256];
  quant_matrix_loader #(.MAX_IDLE(16)) dut (
    .clk(clk), .rst(rst), .req_rst_values(req_rst_values), .req_intra(req_intra),
    .req_non_intra(req_non_intra), .in_dta(in_dta), .in_valid(in_valid), .in_ready(in_ready),
    .wr_addr(wr_addr), .wr_dta(wr_dta), .wr_en_intra(wr_en_intra), .wr_en_non_intra(wr_en_non_intra),
    .wr_clk_en(wr_clk_en), .rst_values(rst_values), .hold(hold), .done(done), .timeout(timeout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (wr_en_intra && ni < 256) begin
      ia[ni] = wr_addr;
      idt[ni] = wr_dta;
      ni++;
      wi_cyc = cyc;
    end
    if (wr_en_non_intra && nn < 256) begin
      na[nn] = wr_addr;
      ndt[nn] = wr_dta;
      nn++;
      wn_cyc = cyc;
    end
    if ((wr_en_intra || wr_en_non_intra || rst_values) && !wr_clk_en) ce_bad++;
    if (rst_values) begin
      nrv++;
      rv_cyc = cyc;
    end
    if (done) begin
      nd++;
      done_cyc = cyc;
    end
    if (timeout) begin
      nt++;
      nt_all++;
      t_cyc = cyc;
    end
  end
  task automatic chk(string tag, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clr_log();
    ni = 0; nn = 0; nrv = 0; nd = 0; nt = 0;
    wi_cyc = 0; wn_cyc = 0; rv_cyc = 0; done_cyc = 0; t_cyc = 0;
  endtask
  task automatic request(bit r, bit i, bit n);
    req_rst_values = r;
    req_intra = i;
    req_non_intra = n;
    req_edge = cyc + 1;
    step();
    req_rst_values = 1'b0;
    req_intra = 1'b0;
    req_non_intra = 1'b0;
  endtask
  task automatic feed(int n, logic [7:0] base, bit toggle, int rst_at);
    int i = 0, k = 0;
    bit a, pulsed = 1'b0;
    while (i < n && k < 1000) begin
      in_valid = !(toggle && k[0]);
      in_dta = base + 8'(i);
      req_rst_values = i == rst_at && !pulsed;
      if (req_rst_values) pulsed = 1'b1;
      a = in_valid && in_ready;
      step();
      if (a) i++;
      k++;
    end
    in_valid = 1'b0;
    req_rst_values = 1'b0;
    chk("feed_bytes", i, n);
  endtask
  task automatic wait_done(int budget);
    int k = 0;
    while (nd == 0 && k < budget) begin
      step();
      k++;
    end
    step();
    step();
    chk("done_seen", nd, 1);
  endtask
  function automatic int seq_err(bit non, int n, logic [7:0] base);
    int e = 0;
    for (int i = 0; i < n; i++)
      if ((non ? na[i] : ia[i]) != 6'(i) || (non ? ndt[i] : idt[i]) != base + 8'(i)) e++;
    return e;
  endfunction
  initial begin
    clr_log();
    nt_all = 0;
    ce_bad = 0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_hold", int'(hold), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_wr_clk_en", int'(wr_clk_en), 0);
    chk("rst_rst_values", int'(rst_values), 0);
    chk("rst_wr_en", int'(wr_en_intra) + int'(wr_en_non_intra), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_dta", int'(wr_dta), 0);
    in_valid = 1'b1;
    in_dta = 8'hAA;
    repeat (3) step();
    in_valid = 1'b0;
    step();
    chk("idle_in_ready", int'(in_ready), 0);
    chk("idle_hold", int'(hold), 0);
    chk("idle_no_write", ni + nn, 0);
    clr_log();
    request(1'b0, 1'b1, 1'b0);
    chk("req_hold", int'(hold), 1);
    feed(64, 8'h08, 1'b0, -1);
    wait_done(20);
    chk("intra_writes", ni, 64);
    chk("intra_no_non", nn, 0);
    chk("intra_seq", seq_err(1'b0, 64, 8'h08), 0);
    chk("intra_latency", done_cyc - req_edge + 1, 67);
    chk("intra_hold_after", int'(hold), 0);
    chk("intra_ready_after", int'(in_ready), 0);
    clr_log();
    request(1'b1, 1'b1, 1'b1);
    feed(128, 8'h10, 1'b0, -1);
    wait_done(20);
    chk("all_rst_pulses", nrv, 1);
    chk("all_rst_time", rv_cyc - req_edge, 2);
    chk("all_intra_writes", ni, 64);
    chk("all_non_writes", nn, 64);
    chk("all_intra_seq", seq_err(1'b0, 64, 8'h10), 0);
    chk("all_non_seq", seq_err(1'b1, 64, 8'h50), 0);
    chk("all_latency", done_cyc - req_edge + 1, 132);
    chk("all_single_done", nd, 1);
    clr_log();
    request(1'b0, 1'b0, 1'b1);
    feed(64, 8'h40, 1'b1, -1);
    wait_done(20);
    chk("tog_non_writes", nn, 64);
    chk("tog_no_intra", ni, 0);
    chk("tog_seq", seq_err(1'b1, 64, 8'h40), 0);
    chk("tog_done_after_last", done_cyc - wn_cyc, 1);
    clr_log();
    request(1'b0, 1'b1, 1'b0);
    feed(64, 8'h20, 1'b0, 30);
    wait_done(20);
    chk("mid_intra_writes", ni, 64);
    chk("mid_intra_seq", seq_err(1'b0, 64, 8'h20), 0);
    chk("mid_rst_pulses", nrv, 1);
    chk("mid_rst_after_load", rv_cyc - wi_cyc, 1);
    chk("mid_done_after_rst", done_cyc - rv_cyc, 1);
    clr_log();
    request(1'b0, 1'b1, 1'b0);
    feed(20, 8'h60, 1'b0, -1);
    rst = 1'b1;
    step();
    chk("abort_in_ready", int'(in_ready), 0);
    chk("abort_hold", int'(hold), 0);
    chk("abort_wr_en", int'(wr_en_intra), 0);
    chk("abort_wr_clk_en", int'(wr_clk_en), 0);
    chk("abort_wr_addr", int'(wr_addr), 0);
    chk("abort_wr_dta", int'(wr_dta), 0);
    rst = 1'b0;
    step();
    clr_log();
    request(1'b0, 1'b1, 1'b0);
    feed(64, 8'h80, 1'b0, -1);
    wait_done(20);
    chk("restart_addr0", int'(ia[0]), 0);
    chk("restart_writes", ni, 64);
    chk("restart_seq", seq_err(1'b0, 64, 8'h80), 0);
`ifdef QM_WATCHDOG_EN
    clr_log();
    request(1'b0, 1'b1, 1'b1);
    feed(6, 8'h30, 1'b0, -1);
    wait_done(40);
    chk("wd_timeouts", nt, 1);
    chk("wd_timeout_delay", t_cyc - wi_cyc, 16);
    chk("wd_done_after", done_cyc - t_cyc, 1);
    chk("wd_partial_writes", ni, 6);
    chk("wd_hold_after", int'(hold), 0);
    repeat (5) step();
    chk("wd_cleared_ready", int'(in_ready), 0);
    chk("wd_cleared_non", nn, 0);
    chk("wd_cleared_hold", int'(hold), 0);
`else
    chk("no_timeout", nt_all, 0);
`endif
    chk("clk_en_cover", ce_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/quant_matrix_loader.md
# quant_matrix_loader

Sequencer that loads the MPEG-2 quantiser matrices from the header parser's byte stream. It latches per-sequence load and reset requests and accepts 64 zigzag-ordered bytes per matrix over a valid/ready handshake. For each byte it drives the write port of the intra or non-intra quantiser matrix block. While a load is in progress it raises `hold` so the inverse quantiser stalls its reads.

## Interface
Parameters:
- `MAX_IDLE`, default 1023: watchdog limit in cycles without an accepted byte. Used only with `QM_WATCHDOG_EN`.

Ports:
- `clk`  in  1  clock; the block uses only this one clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_rst_values`  in  1  one-cycle pulse at sequence_header: return both matrices to their defaults.
- `req_intra`  in  1  one-cycle pulse: load_intra_quantiser_matrix is set.
- `req_non_intra`  in  1  one-cycle pulse: load_non_intra_quantiser_matrix is set.
- `in_dta`  in  8  matrix byte, in zigzag order.
- `in_valid`  in  1  `in_dta` is valid.
- `in_ready`  out  1  the block accepts a byte this cycle.
- `wr_addr`  out  6  zigzag index of the byte being written.
- `wr_dta`  out  8  byte being written.
- `wr_en_intra`  out  1  write strobe to the intra matrix.
- `wr_en_non_intra`  out  1  write strobe to the non-intra matrix.
- `wr_clk_en`  out  1  clock enable to both matrices.
- `rst_values`  out  1  default-restore strobe to both matrices; valid with `wr_clk_en`.
- `hold`  out  1  high while a reset or load sequence is active.
- `done`  out  1  one-cycle pulse when all pending work is complete.
- `timeout`  out  1  one-cycle pulse when the watchdog aborts a load. Tied to 0 without `QM_WATCHDOG_EN`.

## Operation
- Pending flags `p_rst`, `p_intra`, `p_non`:
  - Each is set by its request pulse and cleared when its sequence is serviced.
  - A request arriving while its flag is already set is absorbed.
- States are one-hot: `IDLE`, `RESET`, `LOAD_I`, `LOAD_N`, `FINISH`.
- Priority when leaving `IDLE` or after a sequence completes: `p_rst`, then `p_intra`, then `p_non`. The intra matrix always loads before the non-intra matrix, matching MPEG-2 header order.
- `IDLE`:
  - Goes to the highest-priority pending state.
  - Stays in `IDLE` if nothing is pending.
  - A request pulse is seen in `IDLE` one cycle after it arrives, because it is registered into its flag first.
- `RESET`:
  - Lasts 1 cycle.
  - Registers `rst_values`=1 and `wr_clk_en`=1 for one cycle, then clears `p_rst`.
- `LOAD_I` / `LOAD_N`:
  - `in_ready`=1.
  - Each accepted byte (`in_valid && in_ready`) increments the 6-bit counter `cnt`.
  - The cycle after acceptance the block registers `wr_addr`=`cnt`, `wr_dta`=`in_dta`, `wr_clk_en`=1, and the matching `wr_en_*`=1.
  - Acceptance of byte 63 clears the state's pending flag and selects the next state by priority, or `FINISH` if nothing is pending.
  - `cnt` resets to 0 on entry to either load state.
- `FINISH`:
  - Lasts 1 cycle.
  - Pulses `done`, then goes to `IDLE`.
- `hold`=1 in every state except `IDLE`. It also goes high in the cycle a request is latched while in `IDLE`.
- A `req_rst_values` arriving mid-load is latched but does not interrupt the load. It is serviced after the current matrix completes, before any other pending load.
- `in_valid` while not in a load state is ignored; `in_ready`=0.
- Reset mid-operation returns to `IDLE` and clears all flags and `cnt`. The matrices keep any partial contents.

## Timing
- Reset values:
  - `in_ready`, `wr_en_*`, `wr_clk_en`, `rst_values`, `hold`, `done`, `timeout` = 0.
  - `wr_addr` = 0, `wr_dta` = 0.
- Every output is registered.
- Write latency from byte acceptance to the `wr_en_*` strobe is 1 cycle.
- One matrix takes a minimum of 64 cycles with `in_valid` held high, at 1 byte per cycle.
- Request to `done` with every byte valid on its first cycle:
  - intra only: 1 (flag) + 1 (`IDLE`) + 64 (load) + 1 (`FINISH`) = 67 cycles.
  - reset + intra + non-intra: 132 cycles.
- `wr_addr` wraps 63 → 0 only through re-entry to a load state. There is no overflow into a following matrix.

## Configuration
- `QM_WATCHDOG_EN` defined:
  - A 10-bit idle counter runs in `LOAD_I` / `LOAD_N`.
  - It resets on each accepted byte.
  - When it reaches `MAX_IDLE`, the block pulses `timeout`, clears `p_intra` and `p_non` (`p_rst` is kept), and goes to `FINISH`, so `done` follows one cycle later.
  - The matrices keep their partial contents. The header parser issues `req_rst_values` to recover.
- `QM_WATCHDOG_EN` undefined:
  - No counter is built.
  - A load waits indefinitely for bytes.
  - `timeout`=0.

## Test plan
- Reset release, then `req_intra`, then bytes 0x08..0x47 streamed on consecutive cycles → 64 `wr_en_intra` strobes with `wr_addr` 0..63 and matching data, `wr_en_non_intra` never high, `done` at cycle 67, `hold` low afterwards.
- `req_rst_values`, `req_intra` and `req_non_intra` asserted in the same cycle → 1-cycle `rst_values`, then the intra load, then the non-intra load, a single `done` at cycle 132.
- `in_valid` toggling 1/0 during `LOAD_N` → exactly 64 writes, addresses contiguous, no duplicated or dropped byte, `done` after the 64th byte.
- `req_rst_values` pulsed at byte 30 of an intra load → the load completes to 63 uninterrupted, then `rst_values` pulses, then `done`.
- `rst` asserted at byte 20 → all outputs go to their reset values next cycle; a following `req_intra` restarts at `wr_addr` 0.
- With `QM_WATCHDOG_EN` and `MAX_IDLE`=16, stop `in_valid` after byte 5 → `timeout` pulses 16 cycles after the last acceptance, `done` 1 cycle later, `hold` drops, pending loads are cleared.
